// File: rtl/stream_deframer.sv
// Frame locator for the FIFO wrapper's read-side word stream: header {SYNC,LEN}, LEN payload words, checksum.
// Forwards payload with SOF/EOF, checks the running sum, and keeps pass/abort/drop counters.
module stream_deframer #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter logic [7:0]  MAX_LEN = 8'd64,
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] idle_q, idle_d;
  logic        first_q, first_d;

  logic [15:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic hdr_sync, len_ok, timeout_hit;

  assign hdr_sync = (in_data[15:8] == SYNC);
  assign len_ok   = (in_data[7:0] != 8'd0) && (in_data[7:0] <= MAX_LEN);
  // A valid word on the cycle the limit would be reached suppresses the timeout.
  assign timeout_hit = !in_valid && (state_q != S_IDLE) && (idle_q == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (in_valid && hdr_sync && len_ok) state_d = S_PAYLOAD;
      S_PAYLOAD: begin
        if (timeout_hit)                       state_d = S_IDLE;
        else if (in_valid && rem_q == 8'd1)    state_d = S_CHECK;
      end
      S_CHECK:   if (timeout_hit || in_valid) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum_d       = sum_q;
    rem_d       = rem_q;
    first_d     = first_q;
    idle_d      = 16'd0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_eof_d   = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (timeout_hit) begin
      frame_err_d = 1'b1;
      err_code_d  = 2'b11;
      err_cnt_d   = err_cnt_q + 16'd1;
    end else if (!in_valid) begin
      if (state_q != S_IDLE) idle_d = idle_q + 16'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!hdr_sync) begin
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
          end else if (len_ok) begin
            sum_d   = in_data;
            rem_d   = in_data[7:0];
            first_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b01;
            err_cnt_d   = err_cnt_q + 16'd1;
          end
        end
        S_PAYLOAD: begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_sof_d   = first_q;
          out_eof_d   = (rem_q == 8'd1);
          first_d     = 1'b0;
          sum_d       = sum_q + in_data;
          rem_d       = rem_q - 8'd1;
        end
        S_CHECK: begin
          if (in_data == sum_q) begin
            frame_ok_d = 1'b1;
            ok_cnt_d   = ok_cnt_q + 16'd1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = 2'b10;
            err_cnt_d   = err_cnt_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q       <= 16'd0;
      rem_q       <= 8'd0;
      idle_q      <= 16'd0;
      first_q     <= 1'b0;
      out_data_q  <= 16'd0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      ok_cnt_q    <= 16'd0;
      err_cnt_q   <= 16'd0;
      drop_cnt_q  <= 8'd0;
    end else begin
      sum_q       <= sum_d;
      rem_q       <= rem_d;
      idle_q      <= idle_d;
      first_q     <= first_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_stream_deframer.sv
// Scoreboard bench for stream_deframer: frame-level generator pushes expected events, a monitor pops them.
module tb_stream_deframer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid, out_sof, out_eof, frame_ok, frame_err, busy;
  logic [1:0]  err_code;
  logic [15:0] ok_cnt, err_cnt;
  logic [7:0]  drop_cnt;

  stream_deframer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // kind: 0 payload word, 1 frame_ok, 2 frame_err
  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] data;
    bit          sof;
    bit          eof;
    logic [1:0]  code;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          exp_ok, exp_err, exp_drop;
  logic [15:0] pl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic push(input int kind, input logic [15:0] data, input bit sof, input bit eof,
                      input logic [1:0] code, input logic [15:0] cnt);
    exp_t e;
    e.cyc = cyc + 1; e.kind = kind; e.data = data; e.sof = sof; e.eof = eof;
    e.code = code; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic gaps(input int gap_max);
    repeat ($urandom_range(gap_max, 0)) drive(1'b0, 16'($urandom));
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [15:0] p[$], input bit use_cs,
                            input logic [15:0] cs_in, input int gap_max);
    logic [15:0] sum, cs;
    sum = {8'hA5, len};
    drive(1'b1, {8'hA5, len});
    for (int i = 0; i < int'(len); i++) begin
      gaps(gap_max);
      sum = sum + p[i];
      drive(1'b1, p[i]);
      push(0, p[i], i == 0, i == int'(len) - 1, 2'b00, 16'd0);
    end
    cs = use_cs ? cs_in : sum;
    gaps(gap_max);
    drive(1'b1, cs);
    if (cs == sum) begin exp_ok++;  push(1, 16'd0, 0, 0, 2'b00, exp_ok[15:0]);  end
    else           begin exp_err++; push(2, 16'd0, 0, 0, 2'b10, exp_err[15:0]); end
  endtask

  task automatic send_badlen(input logic [7:0] len);
    drive(1'b1, {8'hA5, len});
    exp_err++;
    push(2, 16'd0, 0, 0, 2'b01, exp_err[15:0]);
  endtask

  task automatic send_noise(input logic [15:0] w);
    drive(1'b1, w);
    if (exp_drop < 255) exp_drop++;
  endtask

  // Header plus k of len payload words, then silence long enough to abort.
  task automatic send_timeout(input logic [7:0] len, input int k);
    logic [15:0] w;
    drive(1'b1, {8'hA5, len});
    for (int i = 0; i < k; i++) begin
      w = 16'($urandom);
      drive(1'b1, w);
      push(0, w, i == 0, i == int'(len) - 1, 2'b00, 16'd0);
    end
    repeat (1024) drive(1'b0, 16'($urandom));
    exp_err++;
    push(2, 16'd0, 0, 0, 2'b11, exp_err[15:0]);
  endtask

  task automatic make_payload(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(16'($urandom));
  endtask

  task automatic check_status(input string tag);
    drive(1'b0, 16'd0);
    chk({tag, "_drop_cnt"}, {24'd0, drop_cnt}, exp_drop);
    chk({tag, "_ok_cnt"},   {16'd0, ok_cnt},   exp_ok);
    chk({tag, "_err_cnt"},  {16'd0, err_cnt},  exp_err);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing_event: kind %0d not seen, required at cycle %0d, now %0d",
                 q[0].kind, q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (out_valid || frame_ok || frame_err) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          tests++; fails++;
          $display("FAIL unexpected_event: got valid=%0b ok=%0b err=%0b data=%0h at cycle %0d, required none",
                   out_valid, frame_ok, frame_err, out_data, cyc);
        end else begin
          mon_e = q.pop_front();
          case (mon_e.kind)
            0: chk("payload_word",
                   {11'd0, out_valid, frame_ok, frame_err, out_sof, out_eof, out_data},
                   {11'd0, 1'b1, 1'b0, 1'b0, mon_e.sof, mon_e.eof, mon_e.data});
            1: chk("frame_ok_event",
                   {13'd0, out_valid, frame_ok, frame_err, ok_cnt},
                   {13'd0, 1'b0, 1'b1, 1'b0, mon_e.cnt});
            default: chk("frame_err_event",
                   {11'd0, out_valid, frame_ok, frame_err, err_code, err_cnt},
                   {11'd0, 1'b0, 1'b0, 1'b1, mon_e.code, mon_e.cnt});
          endcase
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int kind, timeouts;
    reset = 1'b0; in_valid = 1'b0; in_data = 16'd0;
    exp_ok = 0; exp_err = 0; exp_drop = 0; timeouts = 0;
    #1;
    chk("reset_outputs",
        {out_valid, out_sof, out_eof, frame_ok, frame_err, busy, err_code, drop_cnt, out_data},
        32'd0);
    chk("reset_counters", {ok_cnt, err_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: good 3-word frame
    pl = '{16'h0001, 16'h0002, 16'h0003};
    send_frame(8'd3, pl, 1'b1, 16'hA509, 0);
    check_status("t1");
    chk("t1_ok_cnt_is_1", {16'd0, ok_cnt}, 32'd1);

    // 2: same frame, bad checksum
    send_frame(8'd3, pl, 1'b1, 16'hA50A, 0);
    check_status("t2");
    chk("t2_err_code", {30'd0, err_code}, 32'd2);

    // 3: two dropped words, then a LEN=1 frame whose sum wraps
    send_noise(16'h1234);
    send_noise(16'h5A00);
    pl = '{16'hFFFF};
    send_frame(8'd1, pl, 1'b1, 16'hA500, 0);
    check_status("t3");
    chk("t3_drop_cnt_is_2", {24'd0, drop_cnt}, 32'd2);

    // 4: illegal lengths
    send_badlen(8'd0);
    drive(1'b0, 16'd0);
    chk("t4_busy_after_len0", {31'd0, busy}, 32'd0);
    send_badlen(8'd65);
    check_status("t4");
    chk("t4_err_code", {30'd0, err_code}, 32'd1);

    // 5a: timeout after one of two payload words
    drive(1'b1, 16'hA502);
    drive(1'b1, 16'h0007);
    push(0, 16'h0007, 1, 0, 2'b00, 16'd0);
    repeat (500) drive(1'b0, 16'd0);
    chk("t5_busy_while_waiting", {31'd0, busy}, 32'd1);
    repeat (524) drive(1'b0, 16'd0);
    exp_err++;
    push(2, 16'd0, 0, 0, 2'b11, exp_err[15:0]);
    check_status("t5a");
    chk("t5a_err_code", {30'd0, err_code}, 32'd3);

    // 5b: word arrives on idle cycle 1024, frame completes
    drive(1'b1, 16'hA502);
    drive(1'b1, 16'h0007);
    push(0, 16'h0007, 1, 0, 2'b00, 16'd0);
    repeat (1023) drive(1'b0, 16'd0);
    drive(1'b1, 16'h0008);
    push(0, 16'h0008, 0, 1, 2'b00, 16'd0);
    drive(1'b1, 16'hA511);
    exp_ok++;
    push(1, 16'd0, 0, 0, 2'b00, exp_ok[15:0]);
    check_status("t5b");

    // 6: reset mid-payload
    drive(1'b1, 16'hA504);
    drive(1'b1, 16'h0001);
    push(0, 16'h0001, 1, 0, 2'b00, 16'd0);
    drive(1'b1, 16'h0002);
    push(0, 16'h0002, 0, 0, 2'b00, 16'd0);
    drive(1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_outputs_in_reset",
        {out_valid, out_sof, out_eof, frame_ok, frame_err, busy, err_code, drop_cnt, out_data},
        32'd0);
    chk("t6_counters_in_reset", {ok_cnt, err_cnt}, 32'd0);
    chk("t6_no_pending_events", q.size(), 32'd0);
    q.delete();
    exp_ok = 0; exp_err = 0; exp_drop = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send_noise(16'h0001);
    check_status("t6_drop");
    make_payload(4);
    send_frame(8'd4, pl, 1'b0, 16'd0, 0);
    check_status("t6_frame");

    // randomized mix, including back-to-back frames
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(9, 0);
      if (kind <= 4) begin
        make_payload($urandom_range(64, 1));
        send_frame(8'(pl.size()), pl, 1'b0, 16'd0, $urandom_range(2, 0));
      end else if (kind == 5) begin
        make_payload($urandom_range(64, 1));
        w = 16'($urandom);
        send_frame(8'(pl.size()), pl, 1'b1, w, $urandom_range(2, 0));
      end else if (kind == 6) begin
        send_badlen(($urandom_range(1, 0) == 1) ? 8'd0 : 8'($urandom_range(255, 65)));
      end else if (kind == 8 && timeouts < 3) begin
        timeouts++;
        w = 16'($urandom_range(64, 1));
        send_timeout(w[7:0], $urandom_range(int'(w[7:0]), 0));
      end else begin
        w = 16'($urandom);
        if (w[15:8] == 8'hA5) w[15:8] = 8'h00;
        send_noise(w);
      end
    end
    check_status("random");

    // drop counter saturation
    for (int n = 0; n < 300; n++) begin
      w = 16'($urandom);
      if (w[15:8] == 8'hA5) w[15:8] = 8'h3C;
      send_noise(w);
    end
    check_status("saturate");
    chk("saturate_drop_255", {24'd0, drop_cnt}, 32'd255);

    repeat (5) drive(1'b0, 16'd0);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
